// File: rtl/vga_frame_scheduler.sv
// VGA 640x480 timing generator with a per-frame update handshake toward game logic.
// All outputs are registered from the next-count values so they align with pixel_x/pixel_y.
module vga_frame_scheduler #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk_25MHz,
    input  logic        rst_n,
    input  logic        upd_ack,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        frame_start,
    output logic        upd_req,
    output logic        overrun,
    output logic [15:0] frame_count,
    output logic [7:0]  missed_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [9:0]  x_next, y_next;
    logic        at_origin, at_vblank, overrun_next;

    always_comb begin
        x_next = pixel_x + 10'd1;
        y_next = pixel_y;
        if (pixel_x == H_LAST) begin
            x_next = 10'd0;
            y_next = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
        end
        at_origin = (x_next == 10'd0) && (y_next == 10'd0);
        at_vblank = (x_next == 10'd0) && (y_next == V_VIS);
    end

    // Ack sampled on the deadline edge beats the deadline itself.
    always_comb begin
        state_next   = state;
        overrun_next = 1'b0;
        case (state)
            IDLE: if (at_vblank) state_next = REQ;
            REQ: begin
                if (upd_ack) begin
                    state_next = at_origin ? IDLE : DONE;
                end else if (at_origin) begin
                    state_next   = IDLE;
                    overrun_next = 1'b1;
                end
            end
            DONE: if (at_origin) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            state        <= IDLE;
            pixel_x      <= 10'd0;
            pixel_y      <= 10'd0;
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            video_on     <= 1'b1;
            frame_start  <= 1'b0;
            upd_req      <= 1'b0;
            overrun      <= 1'b0;
            frame_count  <= 16'd0;
            missed_count <= 8'd0;
        end else begin
            state       <= state_next;
            pixel_x     <= x_next;
            pixel_y     <= y_next;
            hsync       <= !((x_next >= HS_START) && (x_next <= HS_END));
            vsync       <= !((y_next >= VS_START) && (y_next <= VS_END));
            video_on    <= (x_next < H_VIS) && (y_next < V_VIS);
            frame_start <= at_origin;
            upd_req     <= (state_next == REQ);
            overrun     <= overrun_next;
            if (at_origin)
                frame_count <= frame_count + 16'd1;
            if (overrun_next && (missed_count != 8'hFF))
                missed_count <= missed_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Directed bench: a full-size instance checks one 800-clock line; a shrunken instance
// (15x10 frame) covers frames, handshake, deadline, mid-frame reset and saturation.
module tb_vga_frame_scheduler;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Full 640x480 instance
    logic        rst_n_a, ack_a;
    logic        a_hsync, a_vsync, a_video_on, a_frame_start, a_upd_req, a_overrun;
    logic [9:0]  a_x, a_y;
    logic [15:0] a_frame_count;
    logic [7:0]  a_missed;

    vga_frame_scheduler dut_a (
        .clk_25MHz(clk), .rst_n(rst_n_a), .upd_ack(ack_a),
        .hsync(a_hsync), .vsync(a_vsync), .video_on(a_video_on),
        .pixel_x(a_x), .pixel_y(a_y), .frame_start(a_frame_start),
        .upd_req(a_upd_req), .overrun(a_overrun),
        .frame_count(a_frame_count), .missed_count(a_missed)
    );

    // Shrunken instance: H 8+2+3+2=15 (hsync low x 10..12), V 6+1+2+1=10 (vsync low y 7..8)
    logic        rst_n_s, ack_s;
    logic        s_hsync, s_vsync, s_video_on, s_frame_start, s_upd_req, s_overrun;
    logic [9:0]  s_x, s_y;
    logic [15:0] s_frame_count;
    logic [7:0]  s_missed;

    vga_frame_scheduler #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_s (
        .clk_25MHz(clk), .rst_n(rst_n_s), .upd_ack(ack_s),
        .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on),
        .pixel_x(s_x), .pixel_y(s_y), .frame_start(s_frame_start),
        .upd_req(s_upd_req), .overrun(s_overrun),
        .frame_count(s_frame_count), .missed_count(s_missed)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n_a = 1'b0; rst_n_s = 1'b0; ack_a = 1'b0; ack_s = 1'b0;
        repeat (3) step();
        n_cmp++; if ({s_x, s_y} !== 20'd0) begin n_bad++; $display("FAIL reset_s_xy got %0d,%0d want 0,0", s_x, s_y); end
        n_cmp++; if ({s_hsync, s_vsync, s_video_on} !== 3'b111) begin n_bad++; $display("FAIL reset_s_sync got %b want 111", {s_hsync, s_vsync, s_video_on}); end
        n_cmp++; if ({s_frame_start, s_upd_req, s_overrun} !== 3'b000) begin n_bad++; $display("FAIL reset_s_pulses got %b want 000", {s_frame_start, s_upd_req, s_overrun}); end
        n_cmp++; if (s_frame_count !== 16'd0 || s_missed !== 8'd0) begin n_bad++; $display("FAIL reset_s_counts got %0d,%0d want 0,0", s_frame_count, s_missed); end
        n_cmp++; if ({a_x, a_y} !== 20'd0 || {a_hsync, a_vsync, a_video_on} !== 3'b111) begin n_bad++; $display("FAIL reset_a got x%0d y%0d sync %b want 0 0 111", a_x, a_y, {a_hsync, a_vsync, a_video_on}); end
    endtask

    task automatic test_line();
        int hs_low = 0, hs_first = -1, vis = 0;
        rst_n_a = 1'b1;
        for (int i = 1; i <= 800; i++) begin
            step();
            n_cmp++; if (a_x !== 10'(i % 800)) begin n_bad++; $display("FAIL line_x got %0d want %0d", a_x, i % 800); end
            if (!a_hsync) begin hs_low++; if (hs_first < 0) hs_first = int'(a_x); end
            if (a_video_on) vis++;
        end
        n_cmp++; if (a_y !== 10'd1) begin n_bad++; $display("FAIL line_y got %0d want 1", a_y); end
        n_cmp++; if (hs_low != 96) begin n_bad++; $display("FAIL line_hsync_len got %0d want 96", hs_low); end
        n_cmp++; if (hs_first != 656) begin n_bad++; $display("FAIL line_hsync_start got %0d want 656", hs_first); end
        n_cmp++; if (vis != 640) begin n_bad++; $display("FAIL line_video_on got %0d want 640", vis); end
    endtask

    // upd_ack held high for the whole frame: entry-edge ack must be ignored, exit one cycle later
    task automatic test_frame();
        int fs = 0, fs_at = -1, vs_low = 0, vis = 0, req = 0, ovr = 0;
        int vs_fx = -1, vs_fy = -1, req_y = -1;
        ack_s = 1'b1;
        rst_n_s = 1'b1;
        for (int i = 1; i <= 150; i++) begin
            step();
            if (s_frame_start) begin fs++; fs_at = i; end
            if (!s_vsync) begin if (vs_low == 0) begin vs_fx = int'(s_x); vs_fy = int'(s_y); end vs_low++; end
            if (s_video_on) vis++;
            if (s_upd_req) begin if (req == 0) req_y = int'(s_y); req++; end
            if (s_overrun) ovr++;
        end
        ack_s = 1'b0;
        n_cmp++; if (fs != 1 || fs_at != 150) begin n_bad++; $display("FAIL frame_start got %0d pulses at %0d want 1 at 150", fs, fs_at); end
        n_cmp++; if (s_frame_count !== 16'd1) begin n_bad++; $display("FAIL frame_count got %0d want 1", s_frame_count); end
        n_cmp++; if (vs_low != 30) begin n_bad++; $display("FAIL frame_vsync_len got %0d want 30", vs_low); end
        n_cmp++; if (vs_fx != 0 || vs_fy != 7) begin n_bad++; $display("FAIL frame_vsync_start got (%0d,%0d) want (0,7)", vs_fx, vs_fy); end
        n_cmp++; if (vis != 48) begin n_bad++; $display("FAIL frame_video_on got %0d want 48", vis); end
        n_cmp++; if (req != 1 || req_y != 6) begin n_bad++; $display("FAIL frame_early_ack got %0d cycles at y%0d want 1 at y6", req, req_y); end
        n_cmp++; if (ovr != 0 || s_missed !== 8'd0) begin n_bad++; $display("FAIL frame_overrun got %0d/%0d want 0/0", ovr, s_missed); end
    endtask

    task automatic wait_req(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step();
            if (s_upd_req) ok = 1'b1;
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_req_timeout got upd_req=0 want 1", tag); end
        else if (s_x !== 10'd0 || s_y !== 10'd6) begin n_bad++; $display("FAIL %s_req_pos got (%0d,%0d) want (0,6)", tag, s_x, s_y); end
    endtask

    task automatic test_handshake();
        bit ok, seen_fs = 1'b0;
        int req = 1, ovr = 0;
        wait_req("hs", ok);
        for (int k = 0; k < 40; k++) begin
            step();
            if (s_upd_req) req++;
        end
        ack_s = 1'b1;
        for (int i = 0; i < 200 && !seen_fs; i++) begin
            step();
            ack_s = 1'b0;
            if (s_upd_req) req++;
            if (s_overrun) ovr++;
            if (s_frame_start) seen_fs = 1'b1;
        end
        n_cmp++; if (req != 41) begin n_bad++; $display("FAIL hs_req_len got %0d want 41", req); end
        n_cmp++; if (!seen_fs || ovr != 0 || s_missed !== 8'd0) begin n_bad++; $display("FAIL hs_overrun got fs%0d ovr%0d missed%0d want 1 0 0", seen_fs, ovr, s_missed); end
    endtask

    task automatic test_deadline_ack();
        bit ok, found = 1'b0;
        wait_req("dl", ok);
        for (int i = 0; i < 200 && !found; i++) begin
            if (s_x == 10'd14 && s_y == 10'd9) found = 1'b1;
            else step();
        end
        n_cmp++; if (!found || !s_upd_req) begin n_bad++; $display("FAIL dl_pre found %0d upd_req %0d want 1 1", found, s_upd_req); end
        ack_s = 1'b1;
        step();
        ack_s = 1'b0;
        n_cmp++; if ({s_frame_start, s_upd_req, s_overrun} !== 3'b100) begin n_bad++; $display("FAIL dl_edge got fs,req,ovr=%b want 100", {s_frame_start, s_upd_req, s_overrun}); end
        n_cmp++; if (s_missed !== 8'd0) begin n_bad++; $display("FAIL dl_missed got %0d want 0", s_missed); end
        // Only IDLE re-arms at the next vblank
        wait_req("dl_idle", ok);
    endtask

    task automatic test_reset_mid();
        int ovr = 0;
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (s_x == 10'd3 && s_y == 10'd7) found = 1'b1;
            else step();
        end
        n_cmp++; if (!found || !s_upd_req) begin n_bad++; $display("FAIL rm_pre found %0d upd_req %0d want 1 1", found, s_upd_req); end
        rst_n_s = 1'b0;
        step();
        rst_n_s = 1'b1;
        n_cmp++; if ({s_x, s_y} !== 20'd0 || {s_hsync, s_vsync, s_video_on} !== 3'b111 ||
                     {s_frame_start, s_upd_req, s_overrun} !== 3'b000 || s_frame_count !== 16'd0 || s_missed !== 8'd0) begin
            n_bad++; $display("FAIL rm_reset got x%0d y%0d sync%b p%b fc%0d mc%0d want 0 0 111 000 0 0",
                              s_x, s_y, {s_hsync, s_vsync, s_video_on}, {s_frame_start, s_upd_req, s_overrun}, s_frame_count, s_missed);
        end
        step();
        n_cmp++; if (s_x !== 10'd1 || s_y !== 10'd0 || s_frame_start !== 1'b0) begin n_bad++; $display("FAIL rm_resume got (%0d,%0d) fs%0d want (1,0) 0", s_x, s_y, s_frame_start); end
        for (int i = 0; i < 59; i++) begin
            step();
            if (s_overrun) ovr++;
        end
        n_cmp++; if (ovr != 0 || s_upd_req !== 1'b0 || s_x !== 10'd0 || s_y !== 10'd4) begin
            n_bad++; $display("FAIL rm_after got ovr%0d req%0d (%0d,%0d) want 0 0 (0,4)", ovr, s_upd_req, s_x, s_y);
        end
    endtask

    task automatic test_overrun_sat();
        int ovr = 0, stray = 0;
        ack_s = 1'b0;
        for (int i = 0; i < 300 * 150; i++) begin
            step();
            if (s_overrun) ovr++;
            if (s_overrun && !s_frame_start) stray++;
        end
        n_cmp++; if (ovr != 300 || stray != 0) begin n_bad++; $display("FAIL sat_pulses got %0d (stray %0d) want 300 (0)", ovr, stray); end
        n_cmp++; if (s_missed !== 8'd255) begin n_bad++; $display("FAIL sat_missed got %0d want 255", s_missed); end
        n_cmp++; if (s_frame_count !== 16'd300) begin n_bad++; $display("FAIL sat_frame_count got %0d want 300", s_frame_count); end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_handshake();
        test_deadline_ack();
        test_reset_mid();
        test_overrun_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_frame_scheduler.md
VGA_FRAME_SCHEDULER -- requirements
Module: vga_frame_scheduler

Interface
REQ-001 H_ACTIVE, 640, visible pixels per line SHALL be a parameter.
REQ-002 H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal porch and sync widths in clocks SHALL be parameters (line total 800).
REQ-003 V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical porch and sync widths in lines SHALL be parameters (frame total 525).
REQ-004 clk_25MHz  input  1  pixel clock; the only clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset; SHALL be synchronous and active-low.
REQ-006 upd_ack  input  1  game logic has finished its per-frame position update.
REQ-007 hsync  output  1  horizontal sync, active-low.
REQ-008 vsync  output  1  vertical sync, active-low.
REQ-009 video_on  output  1  high while the current pixel is in the visible region.
REQ-010 pixel_x  output  10  current horizontal count, 0..799.
REQ-011 pixel_y  output  10  current vertical count, 0..524.
REQ-012 frame_start  output  1  one-cycle pulse when the counts become (0,0).
REQ-013 upd_req  output  1  update window open; game logic may modify state.
REQ-014 overrun  output  1  one-cycle pulse when an update window closes without an ack.
REQ-015 frame_count  output  16  completed frames, modulo 65536.
REQ-016 missed_count  output  8  overrun events, saturating at 255.

Function
REQ-017 pixel_x SHALL increment by 1 each clock and wrap from H_total-1 (799) to 0.
REQ-018 pixel_y SHALL increment only on the clock where pixel_x wraps, and SHALL wrap from V_total-1 (524) to 0 on that same clock.
REQ-019 All outputs SHALL be registered and aligned with pixel_x/pixel_y: each output SHALL reflect the counts it is presented with, with zero added latency.
REQ-020 hsync SHALL be 0 when pixel_x is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751], and 1 otherwise.
REQ-021 vsync SHALL be 0 when pixel_y is in [490,491], and 1 otherwise.
REQ-022 video_on SHALL be 1 when pixel_x<640 and pixel_y<480, and 0 otherwise.
REQ-023 frame_start SHALL be 1 only on the cycle where the counts are (0,0), excluding the reset cycle.
REQ-024 frame_count SHALL increment on the same edge that asserts frame_start.
REQ-025 The handshake FSM SHALL have three states: IDLE, REQ and DONE.
REQ-026 IDLE->REQ SHALL occur on the edge where the counts become (0,480), the first vblank cycle; upd_req SHALL be 1 in REQ only.
REQ-027 In REQ, upd_ack sampled high SHALL move the FSM to DONE, and upd_req SHALL be low on the next cycle.
REQ-028 upd_ack SHALL be ignored in IDLE and DONE.
REQ-029 An upd_ack already high on the REQ-entry edge SHALL NOT count; the earliest exit is one cycle after upd_req rises.
REQ-030 If the FSM is still in REQ when the counts become (0,0), then on that edge: REQ->IDLE, upd_req=0, overrun pulses 1 for one cycle, and missed_count increments unless it is 255.
REQ-031 DONE->IDLE SHALL occur when the counts become (0,0).
REQ-032 If upd_ack is high on the same edge as the (0,0) deadline, the ack SHALL win: no overrun, and the FSM goes to IDLE.

Reset
REQ-033 On a clock edge with rst_n=0, the block SHALL set: pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=1, frame_start=0, upd_req=0, overrun=0, frame_count=0, missed_count=0, FSM=IDLE.
REQ-034 A reset asserted mid-frame or during REQ SHALL abort the frame with no overrun pulse; counting SHALL resume from (0,0) on the first edge with rst_n=1.

Verification
REQ-035 Release reset, run 800 clocks -> pixel_x goes 0..799 then 0, pixel_y=1; hsync low for exactly 96 clocks starting at x=656.
REQ-036 Run one full frame (420000 clocks) -> frame_start pulses once, frame_count=1, vsync low for exactly 1600 clocks starting at (0,490), and video_on is high for exactly 307200 clocks.
REQ-037 Assert upd_ack 100 clocks after upd_req rises at (0,480) -> upd_req is high for exactly 101 cycles, with no overrun and missed_count=0.
REQ-038 Hold upd_ack=0 for 300 frames -> overrun pulses at each (0,0) that follows a vblank, and missed_count saturates at 255.
REQ-039 Assert upd_ack only on the deadline edge (counts 524/799 -> 0/0) -> no overrun, and FSM=IDLE.
REQ-040 Assert rst_n=0 for 1 cycle at (300,500) with upd_req=1 -> all outputs take their reset values, and no overrun pulse occurs.
